// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port frame-buffer arbiter, VGA scan-out vs pixel writer.
// Define FB_UPSCALE_EN for a half-resolution buffer shown as 2x2 blocks.
module vga_fb_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_tick,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              DE,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [7:0]        drop_cnt
);

`ifdef FB_UPSCALE_EN
  localparam int FB_W = H_RES / 2;
  localparam int FB_H = V_RES / 2;
`else
  localparam int FB_W = H_RES;
  localparam int FB_H = V_RES;
`endif
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(FB_DEPTH);

  typedef enum logic [1:0] {
    DISP,
    CAPT,
    WRITE_OK
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        slot_q, slot_d;
  logic              blank_q;
  logic [DATA_W-1:0] pix_data_q;
  logic              pix_valid_q;
  logic [7:0]        drop_q;
  logic              drop_inc;
  logic              disp_req;
  logic              oob;
  logic [ADDR_W-1:0] x_a, y_a, disp_addr;

`ifdef FB_UPSCALE_EN
  assign x_a = ADDR_W'(x_pixel >> 1);
  assign y_a = ADDR_W'(y_pixel >> 1);
`else
  assign x_a = ADDR_W'(x_pixel);
  assign y_a = ADDR_W'(y_pixel);
`endif
  assign disp_addr = y_a * FB_W_A + x_a;
  assign oob       = (wr_addr >= DEPTH_A);

  // slot position within the pixel; saturates when no strobe arrives
  always_comb begin
    slot_d = slot_q;
    if (pix_tick)
      slot_d = 2'd0;
    else if (slot_q != 2'd3)
      slot_d = slot_q + 2'd1;
  end

  assign disp_req = pix_tick & DE & (slot_d == 2'd0);

  // state of the current cycle and the memory/handshake outputs it implies
  always_comb begin
    state_d   = state_q;
    wr_ack    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    drop_inc  = 1'b0;
    unique case (state_q)
      DISP:     state_d = CAPT;
      CAPT:     state_d = disp_req ? DISP : WRITE_OK;
      WRITE_OK: state_d = disp_req ? DISP : WRITE_OK;
      default:  state_d = WRITE_OK;
    endcase
    if (reset_n) begin
      if (state_d == DISP) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (wr_req) begin
        wr_ack = 1'b1;
        if (oob) begin
          drop_inc = 1'b1;
        end else begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
      end
    end
  end

  // state and slot registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WRITE_OK;
      slot_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // capture read data (or black during blanking) one cycle after the slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q     <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      blank_q     <= pix_tick & ~DE;
      pix_valid_q <= (state_d == CAPT) | blank_q;
      if (state_d == CAPT)
        pix_data_q <= mem_rdata;
      else if (blank_q)
        pix_data_q <= '0;
    end
  end

  // saturating count of dropped out-of-range writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_q <= '0;
    else if (drop_inc && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign drop_cnt  = drop_q;

endmodule
